// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and funct3 constants for the data-memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, load extension and access legality check
//
// Ports:
//   we       in   1   1 = store, 0 = load
//   funct3   in   3   RV32I size/signedness field
//   addr_lo  in   2   byte offset within the word
//   wrdata   in   32  store data (rs2)
//   rdword   in   32  current RAM word at the addressed index
//   byte_en  out  4   lanes to write; all zero for loads and errors
//   wr_word  out  32  store data replicated into every lane it may occupy
//   rd_ext   out  32  extended load result; zero for stores and errors
//   err      out  1   misaligned or illegal access
module lsu_align
    import mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wrdata,
    input  logic [31:0] rdword,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] rd_ext,
    output logic        err
);

    // Addressed byte/half moved down to bit 0; halves are only legal at offsets 0 and 2.
    logic [15:0] lane_data;

    always_comb begin
        lane_data = 16'(rdword >> {addr_lo, 3'b000});
        byte_en   = 4'b0000;
        wr_word   = 32'd0;
        rd_ext    = 32'd0;
        err       = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en = 4'b0001 << addr_lo;
                wr_word = {4{wrdata[7:0]}};
                rd_ext  = {{24{lane_data[7]}}, lane_data[7:0]};
            end
            F3_H: begin
                err     = addr_lo[0];
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wrdata[15:0]}};
                rd_ext  = {{16{lane_data[15]}}, lane_data[15:0]};
            end
            F3_W: begin
                err     = (addr_lo != 2'b00);
                byte_en = 4'b1111;
                wr_word = wrdata;
                rd_ext  = rdword;
            end
            F3_BU: begin
                err    = we;
                rd_ext = {24'd0, lane_data[7:0]};
            end
            F3_HU: begin
                err    = we | addr_lo[0];
                rd_ext = {16'd0, lane_data[15:0]};
            end
            default: err = 1'b1;
        endcase
        if (err || !we) begin
            byte_en = 4'b0000;
        end
        if (err || we) begin
            rd_ext = 32'd0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - RV32I data-memory responder with wait states and byte-lane RAM
//
// Ports:
//   iClk         in   1   clock, rising edge
//   iRst         in   1   synchronous active-high reset (RAM contents kept)
//   iReq_Valid   in   1   request present
//   oReq_Ready   out  1   high only in IDLE
//   iReq_We      in   1   1 = store, 0 = load
//   iReq_Funct3  in   3   size/signedness
//   iReq_Addr    in   32  byte address
//   iReq_WrData  in   32  store data
//   oRsp_Valid   out  1   one-cycle response pulse
//   oRsp_RdData  out  32  load result, zero outside the pulse
//   oRsp_Err     out  1   misaligned/illegal access, zero outside the pulse
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq_Valid,
    output logic        oReq_Ready,
    input  logic        iReq_We,
    input  logic [2:0]  iReq_Funct3,
    input  logic [31:0] iReq_Addr,
    input  logic [31:0] iReq_WrData,
    output logic        oRsp_Valid,
    output logic [31:0] oRsp_RdData,
    output logic        oRsp_Err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    mem_state_t  state;
    logic [3:0]  wait_cnt;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wrdata;

    logic [31:0] mem [DEPTH_WORDS];

    // With no wait states the access happens on the accept edge itself, so the
    // alignment logic must see the live inputs in IDLE rather than the latch.
    logic        cur_we;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wrdata;
    logic [AW-1:0] word_idx;
    logic        accept;
    logic        enter_resp;

    logic [3:0]  byte_en;
    logic [31:0] wr_word;
    logic [31:0] rd_ext;
    logic        acc_err;

    logic        unused_addr_bits;

    always_comb begin
        cur_we     = (state == IDLE) ? iReq_We     : req_we;
        cur_funct3 = (state == IDLE) ? iReq_Funct3 : req_funct3;
        cur_addr   = (state == IDLE) ? iReq_Addr   : req_addr;
        cur_wrdata = (state == IDLE) ? iReq_WrData : req_wrdata;
        word_idx   = cur_addr[AW+1:2];
        accept     = (state == IDLE) && iReq_Valid && oReq_Ready;
        enter_resp = (accept && !HAS_WAIT) || ((state == WAIT) && (wait_cnt == 4'd0));
    end

    // Address bits above the RAM window wrap silently.
    assign unused_addr_bits = ^cur_addr[31:AW+2];

    lsu_align u_align (
        .we      (cur_we),
        .funct3  (cur_funct3),
        .addr_lo (cur_addr[1:0]),
        .wrdata  (cur_wrdata),
        .rdword  (mem[word_idx]),
        .byte_en (byte_en),
        .wr_word (wr_word),
        .rd_ext  (rd_ext),
        .err     (acc_err)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            oReq_Ready  <= 1'b0;
            oRsp_Valid  <= 1'b0;
            oRsp_RdData <= 32'd0;
            oRsp_Err    <= 1'b0;
            req_we      <= 1'b0;
            req_funct3  <= 3'd0;
            req_addr    <= 32'd0;
            req_wrdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    oReq_Ready <= 1'b1;
                    if (accept) begin
                        req_we     <= iReq_We;
                        req_funct3 <= iReq_Funct3;
                        req_addr   <= iReq_Addr;
                        req_wrdata <= iReq_WrData;
                        oReq_Ready <= 1'b0;
                        wait_cnt   <= WAIT_LOAD;
                        state      <= HAS_WAIT ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    oReq_Ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    oReq_Ready <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                oRsp_Valid  <= 1'b1;
                oRsp_RdData <= rd_ext;
                oRsp_Err    <= acc_err;
            end else begin
                oRsp_Valid  <= 1'b0;
                oRsp_RdData <= 32'd0;
                oRsp_Err    <= 1'b0;
            end
        end
    end

    // RAM has no reset; a reset cycle blocks any write that has not happened yet.
    always_ff @(posedge iClk) begin
        if (!iRst && enter_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

endmodule
